// File: rtl/frequency_decoder_if.sv
// Signal bundle between the frequency-encoder side (master) and the decoder (slave).
// Handshake: data_valid is a one-cycle strobe with no back-pressure; data_output is new
// in the cycle data_valid is high and holds its last value otherwise.
interface frequency_decoder_if #(
    parameter int WIDTH = 8
);
    logic             pulse_input;
    logic             enable;
    logic [WIDTH-1:0] data_output;
    logic             data_valid;
    logic             locked;
    logic             miss_err;
    logic             multi_err;
    logic [1:0]       state_dbg;

    modport master (
        output pulse_input, enable,
        input  data_output, data_valid, locked, miss_err, multi_err, state_dbg
    );

    modport slave (
        input  pulse_input, enable,
        output data_output, data_valid, locked, miss_err, multi_err, state_dbg
    );
endinterface

// File: rtl/frequency_decoder.sv
// Recovers the value carried by the pulse phase within each phase-counter frame and
// tracks lock after LOCK_COUNT consecutive matching single-pulse frames.
module frequency_decoder #(
    parameter int WIDTH      = 8,
    parameter int OFFSET     = 1,
    parameter int LOCK_COUNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    frequency_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] OFFSET_V = WIDTH'(OFFSET);
    localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);
    localparam logic [3:0]       LOCK_V   = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic [1:0]       edge_cnt_q, edge_cnt_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] prev_cand_q, prev_cand_d;
    logic [3:0]       match_q, match_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             miss_q, miss_d;
    logic             multi_q, multi_d;

    logic             edge_det;
    logic             wrap;
    logic [WIDTH-1:0] cand_now;
    logic [1:0]       frame_edges;
    logic [WIDTH-1:0] frame_cand;
    logic [3:0]       match_inc;

    always_comb begin
        edge_det = bus.pulse_input & ~pulse_q;
        wrap     = bus.enable & (cnt_q == '1);
        cand_now = cnt_q - OFFSET_V;

        // Fold this cycle's edge in first so an edge on the wrap cycle closes the ending frame.
        frame_edges = edge_cnt_q;
        frame_cand  = cand_q;
        if (edge_det && (state_q != IDLE)) begin
            if (edge_cnt_q == 2'd0) frame_cand = cand_now;
            if (edge_cnt_q != 2'd2) frame_edges = edge_cnt_q + 2'd1;
        end

        match_inc = ((match_q != 4'd0) && (frame_cand == prev_cand_q)) ? match_q + 4'd1 : 4'd1;

        state_d     = state_q;
        cnt_d       = bus.enable ? cnt_q + ONE_V : cnt_q;
        pulse_d     = bus.pulse_input;
        edge_cnt_d  = frame_edges;
        cand_d      = frame_cand;
        prev_cand_d = prev_cand_q;
        match_d     = match_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        miss_d      = 1'b0;
        multi_d     = 1'b0;

        if (wrap) begin
            edge_cnt_d = 2'd0;
            cand_d     = '0;
            case (state_q)
                IDLE: begin
                    state_d = HUNT;
                    match_d = 4'd0;
                end
                HUNT: begin
                    if (frame_edges == 2'd1) begin
                        match_d     = match_inc;
                        prev_cand_d = frame_cand;
                        if (match_inc >= LOCK_V) begin
                            state_d = LOCKED;
                            data_d  = frame_cand;
                            valid_d = 1'b1;
                        end
                    end else begin
                        match_d = 4'd0;
                        miss_d  = (frame_edges == 2'd0);
                        multi_d = frame_edges[1];
                    end
                end
                LOCKED: begin
                    if (frame_edges == 2'd1) begin
                        data_d  = frame_cand;
                        valid_d = 1'b1;
                    end else begin
                        state_d = HUNT;
                        match_d = 4'd0;
                        miss_d  = (frame_edges == 2'd0);
                        multi_d = frame_edges[1];
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            edge_cnt_q  <= 2'd0;
            cand_q      <= '0;
            prev_cand_q <= '0;
            match_q     <= 4'd0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            miss_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            edge_cnt_q  <= edge_cnt_d;
            cand_q      <= cand_d;
            prev_cand_q <= prev_cand_d;
            match_q     <= match_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            miss_q      <= miss_d;
            multi_q     <= multi_d;
        end
    end

    assign bus.data_output = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.locked      = locked_q;
    assign bus.miss_err    = miss_q;
    assign bus.multi_err   = multi_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_frequency_decoder.sv
// Bench for frequency_decoder: frame-level stimulus with a value scoreboard.
module tb_frequency_decoder;
    localparam int WIDTH      = 8;
    localparam int OFFSET     = 1;
    localparam int LOCK_COUNT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frequency_decoder_if #(.WIDTH(WIDTH)) bus ();

    frequency_decoder #(
        .WIDTH(WIDTH),
        .OFFSET(OFFSET),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int tb_cnt = 0;
    int n_valid, n_miss, n_multi;
    logic [WIDTH-1:0] exp_q[$];

    // One clock: inputs applied, edge, then outputs sampled 1 time unit later.
    task automatic drive_cycle(input logic p, input logic en);
        logic [WIDTH-1:0] exp_v;
        bus.pulse_input = p;
        bus.enable      = en;
        @(posedge clk);
        #1;
        if (en && !rst) tb_cnt = (tb_cnt + 1) % 256;
        if (bus.data_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: data_valid with data_output=%h, nothing expected", bus.data_output);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.data_output !== exp_v) begin
                    errors++;
                    $display("FAIL sb_data: data_output=%h expected %h", bus.data_output, exp_v);
                end
            end
        end
        if (bus.miss_err === 1'b1) n_miss++;
        if (bus.multi_err === 1'b1) n_multi++;
    endtask

    // Runs cycles until one wrap cycle has been driven; pulses start when the phase first equals t1/t2.
    task automatic run_frame(input int t1, input int t2, input bit toggle, input int plen);
        int  left = 0;
        int  guard = 0;
        bit  f1 = 0, f2 = 0, done = 0, wrapping;
        logic en = 1'b1;
        n_valid = 0; n_miss = 0; n_multi = 0;
        while (!done && guard < 1024) begin
            if (!f1 && tb_cnt == t1) begin f1 = 1; left = plen; end
            if (!f2 && tb_cnt == t2) begin f2 = 1; left = plen; end
            wrapping = en && (tb_cnt == 255);
            drive_cycle(left > 0, en);
            if (left > 0) left--;
            if (wrapping) done = 1;
            if (toggle) en = ~en;
            guard++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no wrap after %0d cycles, required one", guard);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        drive_cycle(1'($urandom_range(0, 1)), 1'b1);
        rst = 1'b0;
        tb_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus.data_output !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", bus.data_output); end
        if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.data_valid); end
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b expected 0", bus.locked); end
        if (bus.miss_err !== 1'b0) begin errors++; $display("FAIL rst_miss: got %b expected 0", bus.miss_err); end
        if (bus.multi_err !== 1'b0) begin errors++; $display("FAIL rst_multi: got %b expected 0", bus.multi_err); end
        if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", bus.state_dbg); end
    endtask

    task automatic test_lock();
        for (int f = 0; f < 5; f++) begin
            if (f >= 2) exp_q.push_back(8'h5A);
            run_frame(8'h5B, -1, 0, 1);
            checks += 2;
            if (bus.locked !== (f >= 2)) begin errors++; $display("FAIL lock_state f%0d: locked=%b expected %b", f, bus.locked, f >= 2); end
            if (n_valid != ((f >= 2) ? 1 : 0)) begin errors++; $display("FAIL lock_valid_count f%0d: got %0d expected %0d", f, n_valid, (f >= 2) ? 1 : 0); end
        end
    endtask

    task automatic test_miss();
        run_frame(-1, -1, 0, 1);
        checks += 3;
        if (n_miss != 1) begin errors++; $display("FAIL miss_strobe: count %0d expected 1", n_miss); end
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL miss_unlock: locked=%b expected 0", bus.locked); end
        if (n_valid != 0) begin errors++; $display("FAIL miss_valid: count %0d expected 0", n_valid); end
        run_frame(8'h5B, -1, 0, 1);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL miss_relock1: locked=%b expected 0", bus.locked); end
        exp_q.push_back(8'h5A);
        run_frame(8'h5B, -1, 0, 1);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL miss_relock2: locked=%b expected 1", bus.locked); end
    endtask

    task automatic test_multi();
        run_frame(8'h10, 8'h80, 0, 1);
        checks += 4;
        if (n_multi != 1) begin errors++; $display("FAIL multi_strobe: count %0d expected 1", n_multi); end
        if (n_miss != 0) begin errors++; $display("FAIL multi_nomiss: count %0d expected 0", n_miss); end
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL multi_unlock: locked=%b expected 0", bus.locked); end
        if (bus.data_output !== 8'h5A) begin errors++; $display("FAIL multi_hold: data_output=%h expected 5a", bus.data_output); end
        run_frame(8'h5B, -1, 0, 1);
        exp_q.push_back(8'h5A);
        run_frame(8'h5B, -1, 0, 1);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL multi_relock: locked=%b expected 1", bus.locked); end
    endtask

    task automatic test_wrap_values();
        exp_q.push_back(8'hFF);
        run_frame(8'h00, -1, 0, 1);
        checks += 2;
        if (n_valid != 1) begin errors++; $display("FAIL wrap_zero_valid: count %0d expected 1", n_valid); end
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL wrap_zero_locked: locked=%b expected 1", bus.locked); end
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(8'hFE);
            run_frame(8'hFF, -1, 0, 1);
            checks += 2;
            if (n_valid != 1) begin errors++; $display("FAIL wrap_ff_valid f%0d: count %0d expected 1", f, n_valid); end
            if (bus.locked !== 1'b1) begin errors++; $display("FAIL wrap_ff_locked f%0d: locked=%b expected 1", f, bus.locked); end
        end
    endtask

    task automatic test_enable_toggle();
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(8'h5A);
            run_frame(8'h5B, -1, 1, 2);
            checks += 3;
            if (n_multi != 0) begin errors++; $display("FAIL toggle_multi f%0d: count %0d expected 0", f, n_multi); end
            if (n_valid != 1) begin errors++; $display("FAIL toggle_valid f%0d: count %0d expected 1", f, n_valid); end
            if (bus.locked !== 1'b1) begin errors++; $display("FAIL toggle_locked f%0d: locked=%b expected 1", f, bus.locked); end
        end
    endtask

    task automatic test_random();
        int t;
        for (int f = 0; f < 4; f++) begin
            t = $urandom_range(1, 254);
            exp_q.push_back(8'(t - OFFSET));
            run_frame(t, -1, 0, 1);
            checks += 2;
            if (n_valid != 1) begin errors++; $display("FAIL rand_valid t=%h: count %0d expected 1", t, n_valid); end
            if (bus.locked !== 1'b1) begin errors++; $display("FAIL rand_locked t=%h: locked=%b expected 1", t, bus.locked); end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 100; c++) drive_cycle(1'b0, 1'b1);
        rst = 1'b1;
        drive_cycle(1'b1, 1'b1);
        rst = 1'b0;
        tb_cnt = 0;
        checks += 4;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL mid_rst_locked: got %b expected 0", bus.locked); end
        if (bus.data_output !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", bus.data_output); end
        if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.data_valid); end
        if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d expected 0", bus.state_dbg); end
        for (int f = 0; f < 3; f++) begin
            if (f == 2) exp_q.push_back(8'h5A);
            run_frame(8'h5B, -1, 0, 1);
            checks++;
            if (bus.locked !== (f == 2)) begin errors++; $display("FAIL mid_relock f%0d: locked=%b expected %b", f, bus.locked, f == 2); end
        end
    endtask

    task automatic test_hunt_mismatch();
        do_reset();
        run_frame(8'h20, -1, 0, 1);
        run_frame(8'h20 + 8'h10 * 0, -1, 0, 1);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL hunt_first: locked=%b expected 0", bus.locked); end
        run_frame(8'h30, -1, 0, 1);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL hunt_mismatch: locked=%b expected 0", bus.locked); end
        exp_q.push_back(8'h2F);
        run_frame(8'h30, -1, 0, 1);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL hunt_match: locked=%b expected 1", bus.locked); end
    endtask

    initial begin
        rst = 1'b1;
        bus.pulse_input = 1'b0;
        bus.enable = 1'b0;
        test_reset();
        test_lock();
        test_miss();
        test_multi();
        test_wrap_values();
        test_enable_toggle();
        test_random();
        test_reset_mid();
        test_hunt_mismatch();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected values never produced, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frequency_decoder.md
FREQUENCY_DECODER -- requirements
Module: frequency_decoder

Interface
REQ-001: Parameter WIDTH, default 8, is the width of the phase counter and of the recovered data.
REQ-002: Parameter OFFSET, default 1, is the pulse pipeline delay in enabled counts, subtracted from the captured phase.
REQ-003: Parameter LOCK_COUNT, default 2, is the number of consecutive equal single-pulse frames needed to enter LOCKED (legal range 1..15).
REQ-004: The block SHALL have one clock and a synchronous, active-high reset.
REQ-005: clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-006: rst  input  1  synchronous active-high reset.
REQ-007: pulse_input  input  1  pulse stream from the frequency encoder.
REQ-008: enable  input  1  phase-advance qualifier, the same signal that gates the encoder counter.
REQ-009: data_output  output  WIDTH  last recovered value.
REQ-010: data_valid  output  1  one-cycle strobe; data_output is new this cycle.
REQ-011: locked  output  1  high while in LOCKED.
REQ-012: miss_err  output  1  one-cycle strobe; a frame contained no pulse edge.
REQ-013: multi_err  output  1  one-cycle strobe; a frame contained two or more pulse edges.

Function
REQ-014: Phase counter cnt (WIDTH bits) SHALL increment modulo 2^WIDTH on each cycle with enable=1 and hold otherwise.
REQ-015: Wrap event = enable=1 and cnt = 2^WIDTH-1; a frame is the span between consecutive wrap events.
REQ-016: pulse_input SHALL be registered once (pulse_q); edge = pulse_input & ~pulse_q, evaluated every cycle regardless of enable.
REQ-017: On an edge, the candidate SHALL be (cnt - OFFSET) mod 2^WIDTH, using the pre-increment cnt of that cycle.
REQ-018: The per-frame edge count SHALL saturate at 2; the first edge's candidate is kept and later edges do not overwrite it.
REQ-019: An edge in the same cycle as a wrap event SHALL belong to the ending frame.
REQ-020: State IDLE (after reset): edges ignored; the first wrap event moves to HUNT with edge count 0 and match count 0.
REQ-021: HUNT, at a wrap event with exactly 1 edge: match count = previous count+1 if candidate equals the previous HUNT candidate, else 1; when it reaches LOCK_COUNT, go to LOCKED.
REQ-022: On the HUNT-to-LOCKED transition, data_output SHALL take the candidate with data_valid=1.
REQ-023: HUNT, 0 or >=2 edges at a wrap event: match count reset to 0, stay in HUNT, and pulse the matching error.
REQ-024: LOCKED, at a wrap event with exactly 1 edge: data_output = candidate and data_valid=1, including when the value changed.
REQ-025: LOCKED, at a wrap event with 0 edges: miss_err=1, go to HUNT with match count 0.
REQ-026: LOCKED, at a wrap event with >=2 edges: multi_err=1, go to HUNT with match count 0.
REQ-027: All outputs SHALL be registered and asserted the cycle after the evaluating wrap event; strobes SHALL last exactly one cycle.
REQ-028: Edge count and candidate SHALL clear at every wrap event, after evaluation.

Reset
REQ-029: On rst=1 at a clock edge: cnt, pulse_q, edge count, candidate, match count, data_output = 0; data_valid, locked, miss_err, multi_err = 0; state = IDLE.
REQ-030: Reset mid-frame SHALL discard the partial frame; rst SHALL take priority over every other event in the same cycle.

Verification (WIDTH=8, OFFSET=1, LOCK_COUNT=2 unless stated)
REQ-031: enable=1 and a 1-cycle pulse when cnt=0x5B every frame -> IDLE frame, then locked=1 and data_valid with data_output=0x5A after the 2nd HUNT wrap; data_valid=1 once per frame thereafter.
REQ-032: Locked; one frame with no pulse -> miss_err=1 for 1 cycle, locked=0, relock after 2 good frames.
REQ-033: Locked; pulses at cnt=0x10 and 0x80 in one frame -> multi_err=1, locked=0, data_output holds 0x5A.
REQ-034: Pulse at cnt=0x00 -> captured 0xFF (modulo wrap); pulse coincident with the wrap cycle (cnt=0xFF) -> counted in the ending frame, value 0xFE.
REQ-035: enable toggling 1/0 each cycle, pulse held high 2 cycles -> a single edge per frame, same value as with enable=1, no multi_err.
REQ-036: rst pulsed mid-frame while locked -> all outputs 0 the next cycle, IDLE; relock takes 1 IDLE frame + 2 frames.
